// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/multu/div/divu,
// serves mfhi/mflo reads and mthi/mtlo writes, and reports busy to the hazard unit.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        start,
  input  logic        move_to,
  input  logic        move_from,
  input  logic [2:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result,
  output logic [0:0]  state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  // Handshake: start/move_to are single-cycle strobes from the E stage; they take
  // effect only when busy==0 and req==0. busy stays high for the whole operation.
  logic [CW-1:0] count;
  logic [31:0]   hi_nx;
  logic [31:0]   lo_nx;
  logic          commit_nx;

  logic          is_div;
  logic          op_valid;
  logic          mt_fire;

  logic [63:0]   ext_a;
  logic [63:0]   ext_b;
  logic [63:0]   product;

  logic          neg_a;
  logic          neg_b;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   den;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   quot;
  logic [31:0]   rem;
  logic          div_zero;

  assign is_div   = sel[1];
  assign op_valid = start & ~req & ~busy & (sel[2:1] == 2'b00 || sel[2:1] == 2'b01);
  assign mt_fire  = move_to & ~start & ~req & ~busy;

  // One 64-bit multiplier; sel[0] selects zero- vs sign-extension of the operands.
  always_comb begin
    ext_a   = {(sel[0] ? 32'h0 : {32{a[31]}}), a};
    ext_b   = {(sel[0] ? 32'h0 : {32{b[31]}}), b};
    product = ext_a * ext_b;
  end

  // Signed divide done on magnitudes, so 0x80000000 / -1 yields 0x80000000 rem 0
  // naturally and no signed-overflow case reaches the divider.
  always_comb begin
    neg_a    = ~sel[0] & a[31];
    neg_b    = ~sel[0] & b[31];
    mag_a    = neg_a ? (~a + 32'd1) : a;
    mag_b    = neg_b ? (~b + 32'd1) : b;
    div_zero = (b == 32'h0);
    den      = div_zero ? 32'd1 : mag_b;
    uq       = mag_a / den;
    ur       = mag_a % den;
    quot     = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem      = neg_a ? (~ur + 32'd1) : ur;
  end

  assign result = move_from ? (sel[0] ? lo : hi) : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      count     <= '0;
      hi        <= 32'h0;
      lo        <= 32'h0;
      hi_nx     <= 32'h0;
      lo_nx     <= 32'h0;
      commit_nx <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            state <= S_RUN;
            busy  <= 1'b1;
            if (is_div) begin
              count     <= CW'(DIV_CYCLES);
              hi_nx     <= rem;
              lo_nx     <= quot;
              commit_nx <= ~div_zero;
            end else begin
              count     <= CW'(MULT_CYCLES);
              hi_nx     <= product[63:32];
              lo_nx     <= product[31:0];
              commit_nx <= 1'b1;
            end
          end else if (mt_fire) begin
            if (sel == 3'b000) hi <= a;
            else if (sel == 3'b001) lo <= a;
          end
        end
        S_RUN: begin
          if (count == CW'(1)) begin
            // Divide by zero still burns its cycles but leaves HI/LO alone.
            if (commit_nx) begin
              hi <= hi_nx;
              lo <= lo_nx;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: scoreboard of expected {hi,lo} per operation,
// directed corner cases plus a short randomized operation stream.
module tb_e_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        rst;
  logic        req;
  logic        start;
  logic        move_to;
  logic        move_from;
  logic [2:0]  sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;
  logic [0:0]  state;

  int n_checks;
  int n_fail;

  logic [31:0] model_hi;
  logic [31:0] model_lo;
  logic [63:0] exp_q[$];

  e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .start(start), .move_to(move_to),
    .move_from(move_from), .sel(sel), .a(a), .b(b), .busy(busy), .hi(hi),
    .lo(lo), .result(result), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model_op(input logic [2:0] s, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] h,
                                           input logic [31:0] l);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] p;
    logic [63:0] res;
    res = {h, l};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (s)
      3'b000: begin p = sx * sy; res = p; end
      3'b001: begin p = {32'h0, x} * {32'h0, y}; res = p; end
      3'b010: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        res = {r[31:0], q[31:0]};
      end
      3'b011: if (y != 0) res = {x % y, x / y};
      default: res = {h, l};
    endcase
    return res;
  endfunction

  task automatic idle_inputs();
    req = 1'b0; start = 1'b0; move_to = 1'b0; move_from = 1'b0;
    sel = 3'b000; a = 32'h0; b = 32'h0;
  endtask

  task automatic do_move_to(input logic [2:0] s, input logic [31:0] v, input logic rq);
    @(negedge clk);
    move_to = 1'b1; sel = s; a = v; req = rq;
    if (!rq) begin
      if (s == 3'b000) model_hi = v;
      else if (s == 3'b001) model_lo = v;
    end
    @(negedge clk);
    idle_inputs();
    check("mt_hi", hi, model_hi);
    check("mt_lo", lo, model_lo);
  endtask

  task automatic do_read(input logic [2:0] s, input logic [31:0] expv, input string tag);
    move_from = 1'b1; sel = s;
    #1;
    check(tag, result, expv);
    move_from = 1'b0;
  endtask

  // Drives one operation, pushes its expectation, and waits for busy to drop.
  task automatic do_op(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y,
                       input logic with_mt, input logic peek_lo);
    int n;
    int cnt;
    logic [63:0] e;
    logic [31:0] old_lo;
    n = s[1] ? DIV_CYCLES : MULT_CYCLES;
    old_lo = model_lo;
    @(negedge clk);
    start = 1'b1; move_to = with_mt; sel = s; a = x; b = y;
    exp_q.push_back(model_op(s, x, y, model_hi, model_lo));
    @(negedge clk);
    idle_inputs();
    check("busy_rise", busy, 1'b1);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (peek_lo && cnt == 3) do_read(3'b001, old_lo, "mflo_run");
      @(negedge clk);
    end
    check("busy_len", cnt, n);
    check("state_idle", state, 1'b0);
    e = exp_q.pop_front();
    check("op_hi", hi, e[63:32]);
    check("op_lo", lo, e[31:0]);
    model_hi = e[63:32];
    model_lo = e[31:0];
  endtask

  task automatic blocked_start(input logic [2:0] s, input logic rq);
    @(negedge clk);
    start = 1'b1; sel = s; a = 32'h1234; b = 32'h5; req = rq;
    @(negedge clk);
    idle_inputs();
    check("blk_busy", busy, 1'b0);
    repeat (MULT_CYCLES + 2) @(negedge clk);
    check("blk_hi", hi, model_hi);
    check("blk_lo", lo, model_lo);
  endtask

  initial begin
    logic [2:0]  rs;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0;
    n_fail = 0;
    model_hi = 32'h0;
    model_lo = 32'h0;
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_state", state, 1'b0);
    check("rst_result", result, 32'h0);
    rst = 1'b1;

    // mthi then mfhi
    do_move_to(3'b000, 32'hDEADBEEF, 1'b0);
    do_read(3'b000, 32'hDEADBEEF, "mfhi");

    do_op(3'b000, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);
    do_op(3'b011, 32'd7, 32'd2, 1'b0, 1'b1);
    check("divu_lo", lo, 32'd3);
    do_op(3'b010, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    do_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'h0);

    // divide by zero leaves HI/LO alone
    do_move_to(3'b000, 32'h11, 1'b0);
    do_move_to(3'b001, 32'h22, 1'b0);
    do_op(3'b010, 32'd100, 32'd0, 1'b0, 1'b1);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);

    // req blocks start and move_to; invalid sel never starts
    blocked_start(3'b000, 1'b1);
    blocked_start(3'b100, 1'b0);
    do_move_to(3'b001, 32'hCAFEF00D, 1'b1);
    check("req_mtlo", lo, 32'h22);

    // start wins over move_to
    do_op(3'b001, 32'd6, 32'd7, 1'b1, 1'b0);
    check("both_lo", lo, 32'd42);

    // randomized ops
    for (int i = 0; i < 12; i++) begin
      rs = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        default: ;
      endcase
      do_op(rs, ra, rb, 1'b0, 1'($urandom_range(0, 1)));
    end

    // reset in RUN aborts multu without committing
    @(negedge clk);
    start = 1'b1; sel = 3'b001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_hi = 32'h0;
    model_lo = 32'h0;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    repeat (MULT_CYCLES + 3) @(negedge clk);
    check("abort_hi_late", hi, 32'h0);
    check("abort_lo_late", lo, 32'h0);
    check("abort_state", state, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
